dspb_serum_pio_out_pulse: RTL and testbench

- Avalon-MM slave that drives an output port, the write-side counterpart of the serum-board input PIO.
- Holds a host-written data register with atomic set/clear access.
- Adds a hardware-timed pulse engine: selected bits are forced high for a programmed number of clocks, then released automatically.
- Sits on the Qsys bus next to the input PIO and drives DSPB control strobes and enables.

---
 rtl/dspb_serum_pio_out_pulse_if.sv | 23 ++
 rtl/dspb_serum_pio_out_pulse.sv | 162 ++++++++++++++++
 tb/tb_dspb_serum_pio_out_pulse.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dspb_serum_pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for the serum-board output PIO.
//   address    : word address (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (latency 1)
interface dspb_serum_pio_out_pulse_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/dspb_serum_pio_out_pulse.sv
// Output PIO with atomic set/clear and a hardware-timed pulse engine.
// Optional feature macro: DSPB_PIO_OUT_IRQ_EN (sticky pulse-done interrupt).
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   out_port : output pins = DATA | active pulse mask
//   busy     : pulse engine active
//   irq      : pulse-done interrupt (only with DSPB_PIO_OUT_IRQ_EN)
module dspb_serum_pio_out_pulse #(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       CNT_W       = 16,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  dspb_serum_pio_out_pulse_if.slave   bus,
  output logic [WIDTH-1:0]            out_port,
  output logic                        busy
`ifdef DSPB_PIO_OUT_IRQ_EN
  ,
  output logic                        irq
`endif
);

  localparam logic [2:0] A_DATA     = 3'd0;
  localparam logic [2:0] A_PLEN     = 3'd1;
  localparam logic [2:0] A_STATUS   = 3'd2;
  localparam logic [2:0] A_IRQ_CLR  = 3'd3;
  localparam logic [2:0] A_OUTSET   = 3'd4;
  localparam logic [2:0] A_OUTCLEAR = 3'd5;
  localparam logic [2:0] A_PULSE    = 3'd6;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  data;
  logic [CNT_W-1:0]  plen;
  logic [WIDTH-1:0]  pulse_mask;
  logic [CNT_W-1:0]  cnt;
  logic              irq_pending;

  logic              wr_c;
  logic [WIDTH-1:0]  wd_mask_c;
  logic [CNT_W-1:0]  wd_len_c;
  logic              trig_c;
  logic              expire_c;
  logic [31:0]       rd_mux_c;
  logic              unused_wd_c;

  // Write decode; upper writedata bits beyond WIDTH/CNT_W are don't-care.
  assign wr_c        = bus.chipselect & ~bus.write_n;
  assign wd_mask_c   = bus.writedata[WIDTH-1:0];
  assign wd_len_c    = bus.writedata[CNT_W-1:0];
  assign unused_wd_c = ^bus.writedata;

  // A trigger (start or retrigger) needs a non-zero mask and a non-zero length,
  // so the counter is never loaded with 0 while ACTIVE.
  assign trig_c   = wr_c && (bus.address == A_PULSE) &&
                    (wd_mask_c != '0) && (plen != '0);
  assign expire_c = (state == ACTIVE) && !trig_c && (cnt == CNT_W'(1));

  // Host data register with atomic set/clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
    end else if (wr_c) begin
      case (bus.address)
        A_DATA:     data <= wd_mask_c;
        A_OUTSET:   data <= data | wd_mask_c;
        A_OUTCLEAR: data <= data & ~wd_mask_c;
        default:    data <= data;
      endcase
    end
  end

  // Pulse length register; only sampled at trigger time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      plen <= '0;
    end else if (wr_c && (bus.address == A_PLEN)) begin
      plen <= wd_len_c;
    end
  end

  // Pulse FSM; retrigger wins over decrement and expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pulse_mask <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trig_c) begin
            pulse_mask <= wd_mask_c;
            cnt        <= plen;
            state      <= ACTIVE;
            busy       <= 1'b1;
          end
        end
        ACTIVE: begin
          if (trig_c) begin
            pulse_mask <= pulse_mask | wd_mask_c;
            cnt        <= plen;
          end else if (cnt == CNT_W'(1)) begin
            pulse_mask <= '0;
            cnt        <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

`ifdef DSPB_PIO_OUT_IRQ_EN
  // Sticky pulse-done flag; set beats clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pending <= 1'b0;
    end else if (expire_c) begin
      irq_pending <= 1'b1;
    end else if (wr_c && (bus.address == A_IRQ_CLR)) begin
      irq_pending <= 1'b0;
    end
  end

  assign irq = irq_pending;
`else
  assign irq_pending = 1'b0;
`endif

  // Read mux, registered every cycle regardless of chipselect.
  always_comb begin
    rd_mux_c = '0;
    case (bus.address)
      A_DATA:   rd_mux_c = 32'(data);
      A_PLEN:   rd_mux_c = 32'(plen);
      A_STATUS: rd_mux_c = 32'({cnt, 8'h00}) | (32'(irq_pending) << 1) | 32'(busy);
      A_PULSE:  rd_mux_c = 32'(pulse_mask);
      default:  rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_mux_c;
    end
  end

  assign out_port = data | pulse_mask;

endmodule

// File: tb/tb_dspb_serum_pio_out_pulse.sv
// Self-checking bench for dspb_serum_pio_out_pulse (WIDTH=8, CNT_W=16, RESET_VALUE=8'hA5).
// The reference model tracks each pulse by its absolute end cycle rather than a countdown.
module tb_dspb_serum_pio_out_pulse;

  logic        clk;
  logic        reset_n;
  logic [7:0]  out_port;
  logic        busy;
  logic        irq;

  dspb_serum_pio_out_pulse_if bus_if ();

  dspb_serum_pio_out_pulse #(
    .WIDTH       (8),
    .CNT_W       (16),
    .RESET_VALUE (8'hA5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .out_port (out_port),
    .busy     (busy)
`ifdef DSPB_PIO_OUT_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

`ifndef DSPB_PIO_OUT_IRQ_EN
  assign irq = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_data;
  logic [15:0] m_plen;
  logic [7:0]  m_mask;
  longint      m_end;   // index of the edge at which the current pulse ends
  longint      cyc;     // index of the most recent clock edge
  bit          m_irq;
  logic [31:0] m_rd;

  function automatic bit m_active();
    return m_end > cyc;
  endfunction

  function automatic logic [31:0] m_view(input logic [2:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a)
      3'd0: r = 32'(m_data);
      3'd1: r = 32'(m_plen);
      3'd2: r = (m_active() ? (32'(m_end - cyc) << 8) : 32'h0) |
                (32'(m_irq) << 1) | 32'(m_active());
      3'd6: r = m_active() ? 32'(m_mask) : 32'h0;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit          act_b;
    bit          retrig;
    logic [7:0]  wd8;
    if (!reset_n) begin
      m_data = 8'hA5; m_plen = 16'h0; m_mask = 8'h0;
      m_end = 0; cyc = 0; m_irq = 1'b0; m_rd = 32'h0;
    end else begin
      m_rd   = m_view(bus_if.address);
      cyc    = cyc + 1;
      act_b  = (m_end >= cyc);
      retrig = 1'b0;
      wd8    = bus_if.writedata[7:0];
      if (bus_if.chipselect && !bus_if.write_n) begin
        case (bus_if.address)
          3'd0: m_data = wd8;
          3'd1: m_plen = bus_if.writedata[15:0];
          3'd3: m_irq  = 1'b0;
          3'd4: m_data = m_data | wd8;
          3'd5: m_data = m_data & ~wd8;
          3'd6: if (wd8 != 8'h0 && m_plen != 16'h0) begin
            m_mask = act_b ? (m_mask | wd8) : wd8;
            m_end  = cyc + longint'(m_plen);
            retrig = 1'b1;
          end
          default: ;
        endcase
      end
`ifdef DSPB_PIO_OUT_IRQ_EN
      if (!retrig && act_b && m_end == cyc) m_irq = 1'b1;
`endif
    end
  end

  // Continuous comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_port", 32'(out_port), 32'(m_data | (m_active() ? m_mask : 8'h0)));
      chk("busy", 32'(busy), 32'(m_active()));
      chk("readdata", bus_if.readdata, m_rd);
`ifdef DSPB_PIO_OUT_IRQ_EN
      chk("irq", 32'(irq), 32'(m_irq));
`endif
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.writedata  = d;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  logic [7:0]  s_out [8];
  logic [31:0] s_rd  [8];
  logic        s_busy[8];
  int          n_hi;
  int          n_bz;

  initial begin : stim
    reset_n           = 1'b0;
    bus_if.address    = 3'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Reset value readback
    @(negedge clk);
    chk("rst_readdata", bus_if.readdata, 32'h000000A5);
    chk("rst_out_port", 32'(out_port), 32'hA5);
    chk("rst_busy", 32'(busy), 32'h0);

    // DATA / OUTSET / OUTCLEAR
    bus_write(3'd0, 32'hFFFF_FF0F);
    chk("data_wr", 32'(out_port), 32'h0F);
    bus_write(3'd4, 32'h30);
    chk("outset", 32'(out_port), 32'h3F);
    bus_write(3'd5, 32'h03);
    chk("outclear", 32'(out_port), 32'h3C);
    bus_if.address = 3'd0;
    @(negedge clk);
    chk("data_rd", bus_if.readdata, 32'h3C);

    // Basic 5-cycle pulse
    bus_write(3'd0, 32'h0);
    bus_write(3'd1, 32'd5);
    bus_write(3'd6, 32'h81);
    bus_if.address = 3'd2;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      s_out[i]  = out_port;
      s_rd[i]   = bus_if.readdata;
      s_busy[i] = busy;
    end
    n_hi = 0; n_bz = 0;
    for (int i = 0; i < 8; i++) begin
      if (s_out[i] == 8'h81) n_hi++;
      if (s_busy[i]) n_bz++;
    end
    chk("pulse_len", 32'(n_hi), 32'd5);
    chk("busy_len", 32'(n_bz), 32'd5);
    chk("pulse_after", 32'(s_out[5]), 32'h00);
    for (int i = 1; i <= 5; i++)
      chk("status_cnt", s_rd[i], (32'(6 - i) << 8) | 32'h1);
`ifdef DSPB_PIO_OUT_IRQ_EN
    chk("irq_first", 32'(irq), 32'h1);
    bus_write(3'd3, 32'h0);
    chk("irq_clr_first", 32'(irq), 32'h0);
`endif

    // Retrigger
    bus_write(3'd1, 32'd4);
    bus_write(3'd6, 32'h01);
    chk("retrig_first", 32'(out_port), 32'h01);
    bus_write(3'd6, 32'h02);
    n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_port != 8'h03) break;
      n_hi++;
      @(negedge clk);
    end
    chk("retrig_len", 32'(n_hi), 32'd4);
    chk("retrig_drop", 32'(out_port), 32'h00);
`ifdef DSPB_PIO_OUT_IRQ_EN
    chk("irq_retrig", 32'(irq), 32'h1);
    bus_write(3'd3, 32'h0);
    chk("irq_clr", 32'(irq), 32'h0);
`endif

    // OUTCLEAR on a pulsed bit leaves the pin high until expiry
    bus_write(3'd1, 32'd3);
    bus_write(3'd6, 32'h04);
    bus_write(3'd5, 32'h04);
    chk("clr_during_pulse", 32'(out_port), 32'h04);
    repeat (4) @(negedge clk);

    // Ignored triggers
    bus_write(3'd1, 32'd0);
    bus_write(3'd6, 32'hFF);
    chk("len0_busy", 32'(busy), 32'h0);
    chk("len0_out", 32'(out_port), 32'h00);
    bus_write(3'd1, 32'd3);
    bus_write(3'd6, 32'h100);
    chk("mask0_busy", 32'(busy), 32'h0);
    @(negedge clk);

    // Reset mid-pulse
    bus_write(3'd1, 32'd100);
    bus_write(3'd6, 32'h10);
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", 32'(out_port), 32'hA5);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_if.address = 3'd2;
    @(negedge clk);
    chk("post_rst_status", bus_if.readdata, 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
